inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the PC generator.
- Accepts fetch PCs, issues them to instruction memory over a req/gnt + rvalid split handshake, and tracks outstanding requests.
- Buffers returned instructions with their PCs in an in-order queue toward decode.
- On branch redirect (flush) discards buffered and in-flight instructions.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- DATA_W, 32, instruction word width
- MAX_OUT, 2, maximum outstanding imem requests (power of 2, >=1)
- QDEPTH, 4, instruction queue entries (power of 2, >=2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- pc_i  in  ADDR_W  fetch address from PC generator
- pc_valid_i  in  1  pc_i valid
- pc_ready_o  out  1  pc_i consumed this cycle (producer advances only on pc_valid_i && pc_ready_o)
- flush_i  in  1  branch redirect; kill all younger work
- imem_req_o  out  1  memory request
- imem_addr_o  out  ADDR_W  request address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses in order, >=1 cycle after grant
- imem_rdata_i  in  DATA_W  response instruction
- inst_o  out  DATA_W  head-of-queue instruction
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  queue head valid
- inst_ready_i  in  1  decode accepts head

Behaviour:
- Clock: single clock clk_i; reset rst_i synchronous, active-high.
- Reset: queue empty, outstanding=0, kill=0, state RUN, all registered state cleared. Consequently inst_valid_o=0, imem_req_o=0 and pc_ready_o=0; inst_o and inst_pc_o read 0.
- Counters:
  - live = outstanding - kill.
  - credit = (outstanding < MAX_OUT) && (live + q_count < QDEPTH).
  - Credit guarantees every live response has a queue slot; responses are never back-pressured.
- Request path (combinational):
  - imem_req_o = pc_valid_i && credit && !flush_i.
  - imem_addr_o = pc_i.
  - pc_ready_o = imem_req_o && imem_gnt_i.
- On grant: outstanding += 1; pc_i pushed into pending-PC FIFO (depth MAX_OUT).
- On imem_rvalid_i: outstanding -= 1; pending-PC FIFO pops.
  - If kill > 0: response discarded, kill -= 1.
  - Otherwise: {imem_rdata_i, popped PC} pushed to the instruction queue.
- Grant and response in the same cycle: outstanding unchanged net; both FIFOs push and pop correctly.
- Output: inst_valid_o = (q_count != 0) && !flush_i. Pop on inst_valid_o && inst_ready_i. Zero-latency read of head; response-to-inst_valid_o latency is 1 cycle.
- Flush, on the edge where flush_i=1:
  - Instruction queue cleared.
  - kill <= outstanding - (imem_rvalid_i ? 1 : 0); a same-cycle response is dropped.
  - No new request is issued that cycle.
  - Any decode pop that cycle is void, since inst_valid_o is forced 0.
- FSM:
  - RUN: kill == 0.
  - DRAIN: kill > 0. Entered on flush when post-flush kill > 0; returns to RUN on the cycle kill reaches 0.
  - In DRAIN new requests are allowed, subject to credit; their responses arrive after the killed ones and are kept.
  - A flush in DRAIN recomputes kill from the current outstanding count.
- Wrap-around: queue and pending-PC pointers wrap modulo depth. Full queue is unreachable with correct memory behaviour. An rvalid with outstanding==0 is a protocol error: ignored, with simulation assertion.
- Reset mid-operation overrides everything. Responses arriving after reset for pre-reset requests are the memory's responsibility; the memory is also reset.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Extra output port inst_misalign_o (1 bit).
  - PC with pc_i[1:0] != 0 is not sent to memory (imem_req_o=0). It is accepted with pc_ready_o = credit && !flush_i and enqueued directly as inst_o=0, inst_misalign_o=1, ordered after all live outstanding responses (enqueue waits until live == 0).
- Undefined: no port, no check; all PCs issued to memory unmodified.

Test Plan:
- Reset, then pc_i=0x0,0x4,0x8 with gnt=1 and rvalid 1 cycle later, data 0xA0,0xA4,0xA8, inst_ready_i=1 -> inst_o/inst_pc_o = 0xA0/0x0, 0xA4/0x4, 0xA8/0x8 on consecutive cycles; inst_valid_o first high 2 cycles after first grant.
- inst_ready_i=0, continuous PCs, immediate responses -> pc_ready_o drops after q_count+live=4; exactly 4 entries held; release ready -> 4 in-order pops, then fetch resumes.
- Two outstanding grants (0x10,0x14), flush_i pulsed before responses, then PC 0x40 granted -> responses for 0x10/0x14 dropped, FSM RUN->DRAIN->RUN, only 0x40 instruction appears.
- flush_i coincident with rvalid and with a valid queue head -> inst_valid_o=0 that cycle, response dropped, queue empty next cycle, kill = outstanding-1.
- Grant withheld (gnt=0 for 3 cycles) -> imem_req_o/imem_addr_o held stable, pc_ready_o=0, outstanding unchanged.
- FETCH_MISALIGN_CHK_EN defined, pc_i=0x6 -> no imem_req_o, queue entry with inst_misalign_o=1, inst_pc_o=0x6, after preceding live instructions.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: PC-generator input, imem req/gnt/rvalid port and decode-side queue head.
// FETCH_MISALIGN_CHK_EN adds the inst_misalign_o flag alongside the queue head.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic              pc_ready_o;
  logic              flush_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              inst_misalign_o;
`endif

  // The fetch unit is the imem master and drives the queue-head outputs.
  modport master (
`ifdef FETCH_MISALIGN_CHK_EN
    output inst_misalign_o,
`endif
    input  pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output pc_ready_o, imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHK_EN
    input  inst_misalign_o,
`endif
    output pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  pc_ready_o, imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues PCs to imem, tracks outstanding requests, queues responses for decode.
// Optional FETCH_MISALIGN_CHK_EN: misaligned PCs bypass memory and enqueue a flagged bubble.
module inst_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2,
  parameter int QDEPTH  = 4
) (
  input logic clk_i,
  input logic rst_i,
  inst_fetch_unit_if.master bus
);

  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int PPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int QPW = $clog2(QDEPTH);
  localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUT);
  localparam logic [31:0] QDEPTH_U  = 32'(QDEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state, stateNext;
  logic [OW-1:0]     outstanding, kill, killNext, live;
  logic [QCW-1:0]    qCount;
  logic [ADDR_W-1:0] pendPc [MAX_OUT];
  logic [PPW-1:0]    pendWr, pendRd;
  logic [DATA_W-1:0] qData [QDEPTH];
  logic [ADDR_W-1:0] qPc [QDEPTH];
  logic [QPW-1:0]    qHead, qTail;
  logic              credit, grant, rspValid, rspKeep, qPush, qPop, misPush;
  logic [DATA_W-1:0] pushData;
  logic [ADDR_W-1:0] pushPc;

  // Credit reserves a queue slot for every response that will be kept.
  assign live   = outstanding - kill;
  assign credit = (32'(outstanding) < MAX_OUT_U) && ((32'(live) + 32'(qCount)) < QDEPTH_U);

`ifdef FETCH_MISALIGN_CHK_EN
  logic qMis [QDEPTH];
  logic misalign;

  assign misalign            = bus.pc_i[1:0] != 2'b00;
  assign bus.imem_req_o      = bus.pc_valid_i && credit && !bus.flush_i && !misalign;
  assign misPush             = bus.pc_valid_i && misalign && credit && !bus.flush_i && (live == '0);
  assign bus.pc_ready_o      = (bus.imem_req_o && bus.imem_gnt_i) || misPush;
  assign bus.inst_misalign_o = qMis[qHead];
`else
  assign bus.imem_req_o = bus.pc_valid_i && credit && !bus.flush_i;
  assign misPush        = 1'b0;
  assign bus.pc_ready_o = bus.imem_req_o && bus.imem_gnt_i;
`endif

  assign bus.imem_addr_o  = bus.pc_i;
  assign grant            = bus.imem_req_o && bus.imem_gnt_i;
  assign rspValid         = bus.imem_rvalid_i && (outstanding != '0);
  assign rspKeep          = rspValid && (kill == '0) && !bus.flush_i;
  assign bus.inst_valid_o = (qCount != '0) && !bus.flush_i;
  assign qPop             = bus.inst_valid_o && bus.inst_ready_i;
  assign qPush            = rspKeep || misPush;
  assign pushData         = misPush ? '0 : bus.imem_rdata_i;
  assign pushPc           = misPush ? bus.pc_i : pendPc[pendRd];
  assign bus.inst_o       = qData[qHead];
  assign bus.inst_pc_o    = qPc[qHead];

  always_comb begin
    killNext  = kill;
    stateNext = state;
    if (bus.flush_i) begin
      killNext = outstanding - OW'(rspValid);
    end else if (rspValid && (kill != '0)) begin
      killNext = kill - OW'(1);
    end
    case (state)
      RUN:     if (killNext != '0) stateNext = DRAIN;
      DRAIN:   if (killNext == '0) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      kill        <= '0;
      outstanding <= '0;
      pendWr      <= '0;
      pendRd      <= '0;
      qHead       <= '0;
      qTail       <= '0;
      qCount      <= '0;
      for (int i = 0; i < MAX_OUT; i++) pendPc[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qData[i] <= '0;
        qPc[i]   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
        qMis[i]  <= 1'b0;
`endif
      end
    end else begin
      state       <= stateNext;
      kill        <= killNext;
      outstanding <= outstanding + OW'(grant) - OW'(rspValid);
      if (grant) begin
        pendPc[pendWr] <= bus.pc_i;
        pendWr         <= (pendWr == PPW'(MAX_OUT - 1)) ? '0 : pendWr + PPW'(1);
      end
      if (rspValid) begin
        pendRd <= (pendRd == PPW'(MAX_OUT - 1)) ? '0 : pendRd + PPW'(1);
      end
      // A flush empties the queue; same-cycle pushes and pops are already suppressed.
      if (bus.flush_i) begin
        qHead  <= '0;
        qTail  <= '0;
        qCount <= '0;
      end else begin
        if (qPush) begin
          qData[qTail] <= pushData;
          qPc[qTail]   <= pushPc;
`ifdef FETCH_MISALIGN_CHK_EN
          qMis[qTail]  <= misPush;
`endif
          qTail        <= qTail + QPW'(1);
        end
        if (qPop) qHead <= qHead + QPW'(1);
        qCount <= qCount + QCW'(qPush) - QCW'(qPop);
      end
    end
  end

  rspWithoutReq: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.imem_rvalid_i && (outstanding == '0)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit: in-order fetch, back-pressure, flush/drain, stalled grant.
// The misaligned-PC sequence runs only when FETCH_MISALIGN_CHK_EN is defined.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(2), .QDEPTH(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic gnt,
                               input logic rv, input logic [31:0] rdata,
                               input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    bus.pc_valid_i    = pv;
    bus.pc_i          = pc;
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rdata;
    bus.inst_ready_i  = rdy;
    bus.flush_i       = fl;
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd1);
    checkOutput({tag, "_inst"}, bus.inst_o, inst);
    checkOutput({tag, "_pc"}, bus.inst_pc_o, pc);
  endtask

  initial begin
    bus.pc_valid_i    = 1'b0;
    bus.pc_i          = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.inst_ready_i  = 1'b0;
    bus.flush_i       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    checkOutput("rst_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("rst_pcready", 32'(bus.pc_ready_o), 32'd0);
    checkOutput("rst_inst", bus.inst_o, 32'h0);
    checkOutput("rst_instpc", bus.inst_pc_o, 32'h0);

    $display("[TB] in-order fetch");
    applyStimulus(1, 32'h0, 1, 0, 32'h0, 1, 0);
    checkOutput("t1_req", 32'(bus.imem_req_o), 32'd1);
    checkOutput("t1_addr", bus.imem_addr_o, 32'h0);
    checkOutput("t1_pcready", 32'(bus.pc_ready_o), 32'd1);
    checkOutput("t1_valid0", 32'(bus.inst_valid_o), 32'd0);
    applyStimulus(1, 32'h4, 1, 1, 32'hA0, 1, 0);
    checkOutput("t1_valid1", 32'(bus.inst_valid_o), 32'd0);
    checkOutput("t1_pcready1", 32'(bus.pc_ready_o), 32'd1);
    applyStimulus(1, 32'h8, 1, 1, 32'hA4, 1, 0);
    checkHead("t1_h0", 32'hA0, 32'h0);
    applyStimulus(0, 32'h0, 0, 1, 32'hA8, 1, 0);
    checkHead("t1_h1", 32'hA4, 32'h4);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t1_h2", 32'hA8, 32'h8);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("t1_empty", 32'(bus.inst_valid_o), 32'd0);

    $display("[TB] back-pressure");
    applyStimulus(1, 32'h100, 1, 0, 32'h0, 0, 0);
    applyStimulus(1, 32'h104, 1, 1, 32'hB100, 0, 0);
    applyStimulus(1, 32'h108, 1, 1, 32'hB104, 0, 0);
    applyStimulus(1, 32'h10C, 1, 1, 32'hB108, 0, 0);
    checkOutput("t2_pcready3", 32'(bus.pc_ready_o), 32'd1);
    applyStimulus(1, 32'h110, 1, 1, 32'hB10C, 0, 0);
    checkOutput("t2_pcready4", 32'(bus.pc_ready_o), 32'd0);
    checkOutput("t2_req4", 32'(bus.imem_req_o), 32'd0);
    applyStimulus(1, 32'h110, 1, 0, 32'h0, 0, 0);
    checkOutput("t2_pcready_full", 32'(bus.pc_ready_o), 32'd0);
    checkHead("t2_hold", 32'hB100, 32'h100);
    applyStimulus(1, 32'h110, 1, 0, 32'h0, 1, 0);
    checkOutput("t2_pcready_pop", 32'(bus.pc_ready_o), 32'd0);
    checkHead("t2_p0", 32'hB100, 32'h100);
    applyStimulus(1, 32'h110, 1, 0, 32'h0, 1, 0);
    checkOutput("t2_resume", 32'(bus.pc_ready_o), 32'd1);
    checkHead("t2_p1", 32'hB104, 32'h104);
    applyStimulus(0, 32'h0, 0, 1, 32'hB110, 1, 0);
    checkHead("t2_p2", 32'hB108, 32'h108);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t2_p3", 32'hB10C, 32'h10C);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t2_new", 32'hB110, 32'h110);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("t2_empty", 32'(bus.inst_valid_o), 32'd0);

    $display("[TB] flush with two in flight");
    applyStimulus(1, 32'h10, 1, 0, 32'h0, 1, 0);
    applyStimulus(1, 32'h14, 1, 0, 32'h0, 1, 0);
    checkOutput("t3_pcready", 32'(bus.pc_ready_o), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 1);
    checkOutput("t3_flush_req", 32'(bus.imem_req_o), 32'd0);
    applyStimulus(1, 32'h40, 1, 1, 32'hC010, 1, 0);
    checkOutput("t3_state_drain", 32'(dut.state), 32'd1);
    checkOutput("t3_kill2", 32'(dut.kill), 32'd2);
    checkOutput("t3_req_nocredit", 32'(bus.imem_req_o), 32'd0);
    checkOutput("t3_valid_a", 32'(bus.inst_valid_o), 32'd0);
    applyStimulus(1, 32'h40, 1, 1, 32'hC014, 1, 0);
    checkOutput("t3_req_drain", 32'(bus.imem_req_o), 32'd1);
    checkOutput("t3_pcready_drain", 32'(bus.pc_ready_o), 32'd1);
    checkOutput("t3_state_drain2", 32'(dut.state), 32'd1);
    checkOutput("t3_valid_b", 32'(bus.inst_valid_o), 32'd0);
    applyStimulus(0, 32'h0, 0, 1, 32'hC040, 1, 0);
    checkOutput("t3_state_run", 32'(dut.state), 32'd0);
    checkOutput("t3_valid_c", 32'(bus.inst_valid_o), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t3_kept", 32'hC040, 32'h40);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("t3_empty", 32'(bus.inst_valid_o), 32'd0);

    $display("[TB] flush coincident with response and valid head");
    applyStimulus(1, 32'h20, 1, 0, 32'h0, 0, 0);
    applyStimulus(1, 32'h24, 1, 1, 32'hD020, 0, 0);
    applyStimulus(1, 32'h28, 1, 0, 32'h0, 0, 0);
    checkHead("t4_head", 32'hD020, 32'h20);
    applyStimulus(0, 32'h0, 0, 1, 32'hD024, 1, 1);
    checkOutput("t4_flush_valid", 32'(bus.inst_valid_o), 32'd0);
    applyStimulus(0, 32'h0, 0, 1, 32'hD028, 1, 0);
    checkOutput("t4_cleared", 32'(bus.inst_valid_o), 32'd0);
    checkOutput("t4_kill1", 32'(dut.kill), 32'd1);
    checkOutput("t4_state_drain", 32'(dut.state), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("t4_dropped", 32'(bus.inst_valid_o), 32'd0);
    checkOutput("t4_state_run", 32'(dut.state), 32'd0);
    checkOutput("t4_out0", 32'(dut.outstanding), 32'd0);

    $display("[TB] grant withheld");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h200, 0, 0, 32'h0, 1, 0);
      checkOutput("t5_req", 32'(bus.imem_req_o), 32'd1);
      checkOutput("t5_addr", bus.imem_addr_o, 32'h200);
      checkOutput("t5_pcready", 32'(bus.pc_ready_o), 32'd0);
      checkOutput("t5_out", 32'(dut.outstanding), 32'd0);
    end
    applyStimulus(1, 32'h200, 1, 0, 32'h0, 1, 0);
    checkOutput("t5_granted", 32'(bus.pc_ready_o), 32'd1);
    applyStimulus(0, 32'h0, 0, 1, 32'hE200, 1, 0);
    checkOutput("t5_out1", 32'(dut.outstanding), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t5_head", 32'hE200, 32'h200);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("t5_empty", 32'(bus.inst_valid_o), 32'd0);

`ifdef FETCH_MISALIGN_CHK_EN
    $display("[TB] misaligned pc");
    applyStimulus(1, 32'h300, 1, 0, 32'h0, 0, 0);
    applyStimulus(1, 32'h6, 1, 0, 32'h0, 0, 0);
    checkOutput("t6_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("t6_wait", 32'(bus.pc_ready_o), 32'd0);
    applyStimulus(1, 32'h6, 1, 1, 32'hF300, 0, 0);
    checkOutput("t6_wait2", 32'(bus.pc_ready_o), 32'd0);
    applyStimulus(1, 32'h6, 1, 0, 32'h0, 0, 0);
    checkOutput("t6_accept", 32'(bus.pc_ready_o), 32'd1);
    checkOutput("t6_req2", 32'(bus.imem_req_o), 32'd0);
    checkHead("t6_h0", 32'hF300, 32'h300);
    checkOutput("t6_mis0", 32'(bus.inst_misalign_o), 32'd0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t6_h0b", 32'hF300, 32'h300);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkHead("t6_h1", 32'h0, 32'h6);
    checkOutput("t6_mis1", 32'(bus.inst_misalign_o), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 1, 0);
    checkOutput("t6_empty", 32'(bus.inst_valid_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
